data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_pkg.sv | 47 ++++
 rtl/data_memory_load_align.sv | 34 +++
 rtl/data_memory.sv | 139 +++++++++++++
 tb/tb_data_memory.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// ============================================================================
// Module      : data_memory_pkg
// Description : Load/store opcode constants, access-width encodings and
//               lane helpers shared by the data memory files.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_memory_pkg;

    typedef enum logic [1:0] {
        WIDTH_BYTE    = 2'b00,
        WIDTH_HALF    = 2'b01,
        WIDTH_WORD    = 2'b10,
        WIDTH_ILLEGAL = 2'b11
    } width_e;

    localparam logic [2:0] c_funct3_lb  = 3'b000;
    localparam logic [2:0] c_funct3_lh  = 3'b001;
    localparam logic [2:0] c_funct3_lw  = 3'b010;
    localparam logic [2:0] c_funct3_lbu = 3'b100;
    localparam logic [2:0] c_funct3_lhu = 3'b101;
    localparam logic [2:0] c_funct3_sb  = 3'b000;
    localparam logic [2:0] c_funct3_sh  = 3'b001;
    localparam logic [2:0] c_funct3_sw  = 3'b010;

    // Misaligned halves/words are snapped down to their natural boundary.
    function automatic logic [1:0] align_offset(input width_e width, input logic [1:0] offset);
        case (width)
            WIDTH_HALF: return {offset[1], 1'b0};
            WIDTH_WORD: return 2'b00;
            default:    return offset;
        endcase
    endfunction

    function automatic logic [3:0] lane_enable(input width_e width, input logic [1:0] offset);
        case (width)
            WIDTH_BYTE: return 4'b0001 << offset;
            WIDTH_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            WIDTH_WORD: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory_load_align.sv
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/half of a raw word and sign- or
//               zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import data_memory_pkg::*;
(
    input  logic [31:0] raw_word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  width_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = raw_word_i[8*offset_i +: 8];
        w_half = offset_i[1] ? raw_word_i[31:16] : raw_word_i[15:0];
        case (width_e'(width_i))
            WIDTH_BYTE: result_o = {{24{~unsigned_i & w_byte[7]}}, w_byte};
            WIDTH_HALF: result_o = {{16{~unsigned_i & w_half[15]}}, w_half};
            default:    result_o = raw_word_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// Module      : data_memory
// Description : Byte-enabled 32-bit data memory with one-cycle registered
//               loads, sticky error flag and store counter.
//               Define DATAMEM_MISALIGN_TRAP_EN to trap misaligned accesses
//               instead of force-aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  width_i,
    input  logic        unsigned_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        err_o,
    output logic [31:0] store_count_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    width_e           w_width;
    logic [IDX_W-1:0] w_idx;
    logic             w_active;
    logic             w_illegal;
    logic             w_trap;
    logic             w_store;
    logic             w_load;
    logic [1:0]       w_offset;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_raw_word;
    logic             w_unused_addr;

    logic [31:0] store_count_d, store_count_q;
    logic        err_d, err_q;
    logic        rvalid_d, rvalid_q;
    logic [1:0]  offset_d, offset_q;
    logic [1:0]  width_d, width_q;
    logic        unsigned_d, unsigned_q;

    // Upper address bits alias onto the array.
    assign w_unused_addr = ^addr_i[31:IDX_W+2];

    always_comb begin
        w_width   = width_e'(width_i);
        w_idx     = addr_i[IDX_W+1:2];
        w_active  = req_i & ~rst;
        w_illegal = (w_width == WIDTH_ILLEGAL);
`ifdef DATAMEM_MISALIGN_TRAP_EN
        w_trap    = ((w_width == WIDTH_HALF) && addr_i[0]) ||
                    ((w_width == WIDTH_WORD) && (addr_i[1:0] != 2'b00));
`else
        w_trap    = 1'b0;
`endif
        w_store   = w_active & ~w_illegal & ~w_trap &  write_i;
        w_load    = w_active & ~w_illegal & ~w_trap & ~write_i;
        w_offset  = align_offset(w_width, addr_i[1:0]);
        w_be      = lane_enable(w_width, w_offset);
        case (w_width)
            WIDTH_BYTE: w_wdata = {4{wdata_i[7:0]}};
            WIDTH_HALF: w_wdata = {2{wdata_i[15:0]}};
            default:    w_wdata = wdata_i;
        endcase

        store_count_d = store_count_q + 32'(w_store);
        err_d         = err_q | (w_active & (w_illegal | w_trap));
        rvalid_d      = w_load;
        offset_d      = w_load ? w_offset   : offset_q;
        width_d       = w_load ? width_i    : width_q;
        unsigned_d    = w_load ? unsigned_i : unsigned_q;
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_byte_q;

        always_ff @(posedge clk) begin
            if (w_store && w_be[g]) begin
                mem[w_idx] <= w_wdata[8*g +: 8];
            end
        end

        // Read register only advances on a load so rdata_o holds between loads.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_byte_q <= 8'h00;
            end else if (w_load) begin
                rd_byte_q <= mem[w_idx];
            end
        end

        assign w_raw_word[8*g +: 8] = rd_byte_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_count_q <= '0;
            err_q         <= 1'b0;
            rvalid_q      <= 1'b0;
            offset_q      <= 2'b00;
            width_q       <= 2'b10;
            unsigned_q    <= 1'b0;
        end else begin
            store_count_q <= store_count_d;
            err_q         <= err_d;
            rvalid_q      <= rvalid_d;
            offset_q      <= offset_d;
            width_q       <= width_d;
            unsigned_q    <= unsigned_d;
        end
    end

    load_align u_load_align (
        .raw_word_i (w_raw_word),
        .offset_i   (offset_q),
        .width_i    (width_q),
        .unsigned_i (unsigned_q),
        .result_o   (rdata_o)
    );

    assign rvalid_o      = rvalid_q;
    assign err_o         = err_q;
    assign store_count_o = store_count_q;

endmodule

`default_nettype wire

// File: tb/tb_data_memory.sv
// ============================================================================
// Module      : tb_data_memory
// Description : Self-checking bench for data_memory against a byte-array
//               reference model; directed cases followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory;

    localparam int DEPTH     = 1024;
    localparam int MEM_BYTES = DEPTH * 4;
`ifdef DATAMEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [1:0]  width_i;
    logic        unsigned_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        err_o;
    logic [31:0] store_count_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  model_mem [MEM_BYTES];
    logic [31:0] exp_rdata  = 32'h0;
    logic [31:0] exp_count  = 32'h0;
    logic        exp_err    = 1'b0;
    logic        exp_rvalid = 1'b0;

    always #5 clk = ~clk;

    data_memory #(.DEPTH_WORDS(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .write_i       (write_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .width_i       (width_i),
        .unsigned_i    (unsigned_i),
        .rdata_o       (rdata_o),
        .rvalid_o      (rvalid_o),
        .err_o         (err_o),
        .store_count_o (store_count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the same request, then
    // compare every output against the model.
    task automatic step(input logic r, input logic req, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] w, input logic u);
        int          nbytes;
        int unsigned base;
        logic [31:0] v;
        rst = r; req_i = req; write_i = wr; addr_i = a;
        wdata_i = wd; width_i = w; unsigned_i = u;
        @(posedge clk);
        #1;
        exp_rvalid = 1'b0;
        if (r) begin
            exp_err   = 1'b0;
            exp_count = 32'h0;
            exp_rdata = 32'h0;
        end else if (req) begin
            if (w == 2'b11) begin
                exp_err = 1'b1;
            end else begin
                nbytes = 1 << w;
                if (TRAP_EN && ((a % nbytes) != 0)) begin
                    exp_err = 1'b1;
                end else begin
                    base = a % MEM_BYTES;
                    base = base - (base % nbytes);
                    if (wr) begin
                        for (int i = 0; i < nbytes; i++) model_mem[base + i] = wd[8*i +: 8];
                        exp_count++;
                    end else begin
                        v = 32'h0;
                        for (int i = 0; i < nbytes; i++) v = v | (32'(model_mem[base + i]) << (8*i));
                        if (nbytes < 4 && !u && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
                        exp_rdata  = v;
                        exp_rvalid = 1'b1;
                    end
                end
            end
        end
        chk("rvalid", {31'b0, rvalid_o}, {31'b0, exp_rvalid});
        chk("rdata", rdata_o, exp_rdata);
        chk("err", {31'b0, err_o}, {31'b0, exp_err});
        chk("store_count", store_count_o, exp_count);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 32'h0, 32'h0, 2'b10, 0);
        chk("reset_rdata", rdata_o, 32'h0);
        chk("reset_count", store_count_o, 32'h0);

        // Word store then load
        step(0, 1, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0);
        chk("sw_count", store_count_o, 32'd1);
        step(0, 1, 0, 32'h10, 32'h0, 2'b10, 0);
        chk("lw_rvalid", {31'b0, rvalid_o}, 32'd1);
        chk("lw_data", rdata_o, 32'hDEADBEEF);

        // Byte store, signed/unsigned byte loads, word readback
        step(0, 1, 1, 32'h13, 32'h00000080, 2'b00, 0);
        step(0, 1, 0, 32'h13, 32'h0, 2'b00, 0);
        chk("lb_signed", rdata_o, 32'hFFFFFF80);
        step(0, 1, 0, 32'h13, 32'h0, 2'b00, 1);
        chk("lbu", rdata_o, 32'h00000080);
        step(0, 0, 0, 32'h0, 32'h0, 2'b00, 0);
        chk("rdata_hold", rdata_o, 32'h00000080);
        step(0, 1, 0, 32'h10, 32'h0, 2'b10, 0);
        chk("lw_after_sb", rdata_o, 32'h80ADBEEF);

        // Half store into upper half
        step(0, 1, 1, 32'h20, 32'h0, 2'b10, 0);
        step(0, 1, 1, 32'h22, 32'h00001234, 2'b01, 0);
        step(0, 1, 0, 32'h22, 32'h0, 2'b01, 0);
        chk("lh", rdata_o, 32'h00001234);
        step(0, 1, 0, 32'h20, 32'h0, 2'b10, 0);
        chk("lw_after_sh", rdata_o, 32'h12340000);

        // Illegal width: no write, sticky error, count unchanged
        step(0, 1, 1, 32'h10, 32'hFFFFFFFF, 2'b11, 0);
        chk("illegal_err", {31'b0, err_o}, 32'd1);
        chk("illegal_count", store_count_o, 32'd4);
        step(0, 1, 0, 32'h10, 32'h0, 2'b11, 0);
        chk("illegal_no_rvalid", {31'b0, rvalid_o}, 32'd0);
        step(0, 1, 0, 32'h10, 32'h0, 2'b10, 0);
        chk("illegal_no_write", rdata_o, 32'h80ADBEEF);
        step(1, 0, 0, 32'h0, 32'h0, 2'b10, 0);
        chk("rst_err", {31'b0, err_o}, 32'd0);
        chk("rst_count", store_count_o, 32'd0);

        // Misaligned word load
        step(0, 1, 0, 32'h12, 32'h0, 2'b10, 0);
        if (TRAP_EN) begin
            chk("mis_rvalid", {31'b0, rvalid_o}, 32'd0);
            chk("mis_err", {31'b0, err_o}, 32'd1);
        end else begin
            chk("mis_rvalid", {31'b0, rvalid_o}, 32'd1);
            chk("mis_data", rdata_o, 32'h80ADBEEF);
            chk("mis_err", {31'b0, err_o}, 32'd0);
        end

        // Requests during reset are discarded
        step(1, 1, 0, 32'h10, 32'h0, 2'b10, 0);
        chk("rst_load_rvalid", {31'b0, rvalid_o}, 32'd0);
        step(1, 1, 1, 32'h10, 32'h11111111, 2'b10, 0);
        step(0, 0, 0, 32'h0, 32'h0, 2'b10, 0);
        chk("rst_load_no_late_rvalid", {31'b0, rvalid_o}, 32'd0);
        step(0, 1, 0, 32'h10, 32'h0, 2'b10, 0);
        chk("rst_store_discarded", rdata_o, 32'h80ADBEEF);

        // Address aliasing
        step(0, 1, 1, 32'h1000, 32'hCAFEF00D, 2'b10, 0);
        step(0, 1, 0, 32'h0, 32'h0, 2'b10, 0);
        chk("alias", rdata_o, 32'hCAFEF00D);

        // Fill the whole array so random loads have a defined model value
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 32'(i * 4), $urandom, 2'b10, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] w;
            w = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            step(logic'($urandom_range(0, 199) == 0),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 1)),
                 32'($urandom_range(0, 16383)),
                 $urandom,
                 w,
                 logic'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
